gmp_answer_scorer: RTL and testbench

- Scoring stage directly downstream of the game sequencer and LFSR display path in the mental-math game.
- Tracks the sequencer phase and latches each random term as it leaves the display. Accumulates the terms into a running sum.
- Judges the player's switch answer against that sum and keeps a saturating score, shown as a thermometer on the 7 user LEDs.

---
 rtl/gmp_pkg.sv | 18 +
 rtl/gmp_therm_enc.sv | 28 ++
 rtl/gmp_answer_scorer.sv | 142 ++++++++++++++
 tb/tb_gmp_answer_scorer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gmp_pkg.sv
// Shared types and constants for the mental-math game scoring path.
package gmp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WAIT_ANS,
    JUDGE,
    DONE
  } gmp_state_e;

  localparam logic [3:0] PHASE_IDLE        = 4'd0;
  localparam logic [3:0] PHASE_PLACEHOLDER = 4'd6;

  localparam int DEF_NUM_TERMS = 5;
  localparam int DEF_SCORE_MAX = 7;

endpackage

// File: rtl/gmp_therm_enc.sv
// Score to 7-LED thermometer encoder with a registered output.
module gmp_therm_enc (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] i_score,
  output logic [6:0] o_bar
);

  logic [6:0] w_bar;
  logic [6:0] r_bar;

  // LED i lights when the score exceeds i
  always_comb begin
    w_bar = '0;
    for (int i = 0; i < 7; i++) begin
      w_bar[i] = (i_score > 3'(i));
    end
  end

  // register the bar so it changes on the same edge as the score
  always_ff @(posedge clk) begin
    if (rst) r_bar <= '0;
    else     r_bar <= w_bar;
  end

  assign o_bar = r_bar;

endmodule

// File: rtl/gmp_answer_scorer.sv
// Answer scorer: sums the displayed random terms of a round, judges the
// player's answer and keeps a saturating score shown on the LED bar.
// Optional build macro GMP_SCORE_DECREMENT_EN: a wrong/timeout verdict
// decrements the score (floor 0) instead of clearing it.
module gmp_answer_scorer
  import gmp_pkg::*;
#(
  parameter int NUM_TERMS       = DEF_NUM_TERMS,
  parameter int TERM_W          = 5,
  parameter int SUM_W           = 8,
  parameter int PHASE_ANS_FIRST = 7,
  parameter int PHASE_LAST      = 10,
  parameter int SCORE_MAX       = DEF_SCORE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        phase,
  input  logic [TERM_W-1:0] term_in,
  input  logic [SUM_W-1:0]  answer,
  input  logic              submit,
  output logic [SUM_W-1:0]  sum_out,
  output logic              result_valid,
  output logic              correct,
  output logic [2:0]        score,
  output logic [6:0]        led_bar
);

  gmp_state_e       r_state, w_state_nxt;
  logic [3:0]       r_prev_phase;
  logic [SUM_W-1:0] r_sum, w_sum_nxt;
  logic             r_verdict, w_verdict_nxt;
  logic             r_result_valid;
  logic             r_correct;
  logic [2:0]       r_score, w_score_nxt, w_score_wrong;
  logic             w_chg, w_to_idle, w_to_first, w_prev_term;
  logic             w_in_win, w_prev_win, w_accept;

  function automatic logic [2:0] sat_inc(input logic [2:0] s);
    return (s >= 3'(SCORE_MAX)) ? 3'(SCORE_MAX) : s + 3'd1;
  endfunction

`ifdef GMP_SCORE_DECREMENT_EN
  function automatic logic [2:0] sat_dec(input logic [2:0] s);
    return (s == 3'd0) ? 3'd0 : s - 3'd1;
  endfunction
`endif

  assign w_chg       = (phase != r_prev_phase);
  assign w_to_idle   = w_chg && (phase == PHASE_IDLE);
  assign w_to_first  = w_chg && (phase == 4'd1);
  assign w_prev_term = (r_prev_phase >= 4'd1) && (r_prev_phase <= 4'(NUM_TERMS));
  assign w_in_win    = (phase >= 4'(PHASE_ANS_FIRST)) && (phase <= 4'(PHASE_LAST));
  assign w_prev_win  = (r_prev_phase >= 4'(PHASE_ANS_FIRST)) &&
                       (r_prev_phase <= 4'(PHASE_LAST));
  // a submit landing on the wrap to phase 0 still belongs to the answer window
  assign w_accept    = submit && (w_in_win || (w_to_idle && w_prev_win));

  // round sequencing: next state, running sum and pending verdict
  always_comb begin
    w_state_nxt   = r_state;
    w_sum_nxt     = r_sum;
    w_verdict_nxt = r_verdict;
    case (r_state)
      IDLE: begin
        if (w_to_first) begin
          w_state_nxt = COLLECT;
          w_sum_nxt   = '0;
        end
      end
      COLLECT: begin
        // term_in still shows the term of the phase being left
        if (w_chg && w_prev_term) w_sum_nxt = r_sum + SUM_W'(term_in);
        if (w_to_idle) w_state_nxt = IDLE;
        else if (w_chg && (r_prev_phase == 4'(NUM_TERMS))) w_state_nxt = WAIT_ANS;
      end
      WAIT_ANS: begin
        if (w_accept) begin
          w_state_nxt   = JUDGE;
          w_verdict_nxt = (answer == r_sum);
        end else if (w_to_idle) begin
          w_state_nxt   = JUDGE;
          w_verdict_nxt = 1'b0;
        end
      end
      JUDGE: w_state_nxt = DONE;
      DONE: begin
        if (w_to_idle) begin
          w_state_nxt = IDLE;
        end else if (w_to_first) begin
          w_state_nxt = COLLECT;
          w_sum_nxt   = '0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // score update applied only in the judge cycle
  always_comb begin
`ifdef GMP_SCORE_DECREMENT_EN
    w_score_wrong = sat_dec(r_score);
`else
    w_score_wrong = '0;
`endif
    w_score_nxt = r_score;
    if (r_state == JUDGE) w_score_nxt = r_verdict ? sat_inc(r_score) : w_score_wrong;
  end

  // state, phase history, sum and verdict/score registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_prev_phase   <= '0;
      r_sum          <= '0;
      r_verdict      <= 1'b0;
      r_result_valid <= 1'b0;
      r_correct      <= 1'b0;
      r_score        <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_prev_phase   <= phase;
      r_sum          <= w_sum_nxt;
      r_verdict      <= w_verdict_nxt;
      r_result_valid <= (r_state == JUDGE);
      if (r_state == JUDGE) r_correct <= r_verdict;
      r_score        <= w_score_nxt;
    end
  end

  gmp_therm_enc u_therm (
    .clk     (clk),
    .rst     (rst),
    .i_score (w_score_nxt),
    .o_bar   (led_bar)
  );

  assign sum_out      = r_sum;
  assign result_valid = r_result_valid;
  assign correct      = r_correct;
  assign score        = r_score;

endmodule

// File: tb/tb_gmp_answer_scorer.sv
// Directed bench for gmp_answer_scorer: full rounds, saturation, timeout,
// abort, submit-on-wrap and mid-round reset.
module tb_gmp_answer_scorer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] phase;
  logic [4:0] term_in;
  logic [7:0] answer;
  logic       submit;
  logic [7:0] sum_out;
  logic       result_valid;
  logic       correct;
  logic [2:0] score;
  logic [6:0] led_bar;

  int n_chk  = 0;
  int n_pass = 0;
  int rv_cnt = 0;
  int exp_score = 0;

  localparam logic [24:0] TERMS_A = {5'd1, 5'd20, 5'd10, 5'd7, 5'd3};      // sum 41
  localparam logic [24:0] TERMS_B = {5'd31, 5'd31, 5'd31, 5'd31, 5'd31};  // sum 155

  gmp_answer_scorer dut (
    .clk          (clk),
    .rst          (rst),
    .phase        (phase),
    .term_in      (term_in),
    .answer       (answer),
    .submit       (submit),
    .sum_out      (sum_out),
    .result_valid (result_valid),
    .correct      (correct),
    .score        (score),
    .led_bar      (led_bar)
  );

  always #5 clk = ~clk;

  // count result_valid pulses
  always @(posedge clk) if (result_valid) rv_cnt <= rv_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int next_score(input int s, input bit c);
    if (c) return (s < 7) ? s + 1 : 7;
`ifdef GMP_SCORE_DECREMENT_EN
    return (s > 0) ? s - 1 : 0;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] bar_of(input int s);
    logic [31:0] b;
    b = (32'd1 << s) - 32'd1;
    return b;
  endfunction

  // phases 1..5 then 6; term_in lags the phase by one cycle like the display register
  task automatic collect(input logic [24:0] tv);
    for (int p = 1; p <= 5; p++) begin
      phase = 4'(p);
      tick();
      term_in = tv[(p-1)*5 +: 5];
      tick();
      tick();
    end
    phase = 4'd6;
    tick();
    term_in = 5'd0;
    tick();
  endtask

  task automatic judged(input bit exp_c);
    exp_score = next_score(exp_score, exp_c);
    check("rv_pulse", 32'(result_valid), 32'd1);
    check("correct", 32'(correct), 32'(exp_c));
    check("score", 32'(score), 32'(exp_score));
    check("led_bar", 32'(led_bar), bar_of(exp_score));
  endtask

  // sub_ph: 7..10 submit in that phase, 0 = timeout, 11 = submit on the wrap to 0
  task automatic answer_rnd(input logic [7:0] ans, input int sub_ph, input bit exp_c);
    int rv0;
    rv0 = rv_cnt;
    for (int p = 7; p <= 10; p++) begin
      phase = 4'(p);
      tick();
      if (p == sub_ph) begin
        answer = ans;
        submit = 1'b1;
        tick();
        submit = 1'b0;
        check("rv_early", 32'(result_valid), 32'd0);
        tick();
        judged(exp_c);
        tick();
        check("rv_end", 32'(result_valid), 32'd0);
      end else if (sub_ph >= 7 && sub_ph < 10 && p == 10) begin
        answer = ~ans;
        submit = 1'b1;
        tick();
        submit = 1'b0;
        tick();
      end else begin
        tick();
        tick();
      end
    end
    if (sub_ph == 11) begin
      answer = ans;
      submit = 1'b1;
    end
    phase = 4'd0;
    tick();
    submit = 1'b0;
    if (sub_ph == 0 || sub_ph == 11) begin
      check("rv_early_wrap", 32'(result_valid), 32'd0);
      tick();
      judged(exp_c);
    end
    tick();
    check("rv_low", 32'(result_valid), 32'd0);
    tick();
    check("rv_once", 32'(rv_cnt - rv0), 32'd1);
    check("correct_held", 32'(correct), 32'(exp_c));
  endtask

  initial begin
    int rv0;
    rst = 1'b1; phase = 4'd0; term_in = 5'd0; answer = 8'd0; submit = 1'b0;
    tick();
    tick();
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_correct", 32'(correct), 32'd0);
    check("rst_score", 32'(score), 32'd0);
    check("rst_led", 32'(led_bar), 32'd0);
    rst = 1'b0;
    tick();

    // basic correct round
    collect(TERMS_A);
    check("sum_a", 32'(sum_out), 32'd41);
    answer_rnd(8'd41, 7, 1'b1);

    // max terms, two more correct rounds
    for (int r = 0; r < 2; r++) begin
      collect(TERMS_B);
      check("sum_b", 32'(sum_out), 32'd155);
      answer_rnd(8'd155, 8, 1'b1);
    end
    check("score_three", 32'(score), 32'd3);

    // wrong answer
    collect(TERMS_A);
    answer_rnd(8'd40, 7, 1'b0);

    // eight correct rounds saturate the score
    for (int r = 0; r < 8; r++) begin
      collect(TERMS_B);
      answer_rnd(8'd155, 7 + (r % 4), 1'b1);
    end
    check("score_sat", 32'(score), 32'd7);
    check("led_full", 32'(led_bar), 32'h7F);

    // submit in phase 6 ignored, then timeout
    collect(TERMS_A);
    answer = 8'd41;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    tick();
    check("rv_ph6", 32'(result_valid), 32'd0);
    answer_rnd(8'd41, 0, 1'b0);

    // submit on the same cycle as the wrap to 0
    collect(TERMS_A);
    answer_rnd(8'd41, 11, 1'b1);

    // abort during phase 3
    rv0 = rv_cnt;
    for (int p = 1; p <= 3; p++) begin
      phase = 4'(p);
      tick();
      term_in = TERMS_B[(p-1)*5 +: 5];
      tick();
    end
    phase = 4'd0;
    tick();
    tick();
    tick();
    check("abort_no_rv", 32'(rv_cnt - rv0), 32'd0);
    check("abort_score", 32'(score), 32'(exp_score));
    collect(TERMS_A);
    check("sum_after_abort", 32'(sum_out), 32'd41);
    answer_rnd(8'd41, 9, 1'b1);

    for (int r = 0; r < 3; r++) begin
      collect(TERMS_A);
      answer_rnd(8'd41, 7, 1'b1);
    end
    check("score_pre_rst", 32'(score), 32'(exp_score));

    // reset while waiting for the answer
    collect(TERMS_A);
    phase = 4'd7;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_score = 0;
    check("mid_rst_sum", 32'(sum_out), 32'd0);
    check("mid_rst_rv", 32'(result_valid), 32'd0);
    check("mid_rst_correct", 32'(correct), 32'd0);
    check("mid_rst_score", 32'(score), 32'd0);
    check("mid_rst_led", 32'(led_bar), 32'd0);
    rv0 = rv_cnt;
    phase = 4'd8;
    tick();
    answer = 8'd0;
    submit = 1'b1;
    tick();
    submit = 1'b0;
    tick();
    tick();
    phase = 4'd9; tick();
    phase = 4'd10; tick();
    phase = 4'd0; tick(); tick(); tick();
    check("post_rst_ignored", 32'(rv_cnt - rv0), 32'd0);
    check("post_rst_score", 32'(score), 32'd0);
    collect(TERMS_A);
    check("sum_post_rst", 32'(sum_out), 32'd41);
    answer_rnd(8'd41, 7, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
